flash_burst_reader: RTL and testbench

Parametrised flash read engine for the audio/data path. It takes a command (start word address, word count), then issues Avalon-MM burst reads to the flash controller. Returned beats are buffered in an internal FIFO and presented on a valid/ready output stream, either as full words or split into halfword samples. It replaces the single-read handshake FSM with multi-word bursts, back-pressure and a completion pulse.

---
 rtl/flash_burst_reader_pkg.sv | 12 +
 rtl/flash_burst_reader_if.sv | 25 ++
 rtl/flash_burst_reader_fifo.sv | 46 ++++
 rtl/flash_burst_reader.sv | 122 ++++++++++++
 tb/tb_flash_burst_reader.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_burst_reader_pkg.sv
// Shared types and helpers for the flash burst reader.
package flash_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REQ, S_BEATS, S_DRAIN, S_DONE
  } state_t;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/flash_burst_reader_if.sv
// Avalon-MM burst read bus between the reader (master) and the flash controller (slave).
interface flash_burst_reader_if #(
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 8
);
  localparam int BC_W = $clog2(BURST_MAX) + 1;

  logic              flash_read;
  logic [ADDR_W-1:0] flash_address;
  logic [BC_W-1:0]   flash_burstcount;
  logic              flash_waitrequest;
  logic [DATA_W-1:0] flash_readdata;
  logic              flash_readdatavalid;

  modport master (
    output flash_read, flash_address, flash_burstcount,
    input  flash_waitrequest, flash_readdata, flash_readdatavalid
  );

  modport slave (
    input  flash_read, flash_address, flash_burstcount,
    output flash_waitrequest, flash_readdata, flash_readdatavalid
  );
endinterface

// File: rtl/flash_burst_reader_fifo.sv
// Single-clock FIFO with occupancy count; supports push and pop in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == CW'(DEPTH));
  assign count  = r_cnt;
  assign rdata  = r_mem[r_rp];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= wdata;
  end
endmodule

// File: rtl/flash_burst_reader.sv
// Command-driven flash reader: splits a word range into Avalon bursts sized to fit
// the output FIFO, and streams the buffered words (or halfwords) to the consumer.
module flash_burst_reader
  import flash_reader_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int BURST_MAX  = 8,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int SPLIT      = 0,
  localparam int OUT_W     = (SPLIT != 0) ? DATA_W / 2 : DATA_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic [CNT_W-1:0]     word_count,
  output logic                 busy,
  output logic                 done,
  flash_burst_reader_if.master flash,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int BC_W = $clog2(BURST_MAX) + 1;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  state_t              r_state, w_nxt;
  logic [ADDR_W-1:0]   r_cur_addr, r_faddr;
  logic [CNT_W-1:0]    r_remaining;
  logic [BC_W-1:0]     r_beats_left, r_bc, w_len;
  logic                r_read, r_busy, r_done, r_half;
  logic                w_push, w_pop, w_empty, w_full, w_last_beat;
  logic [CW-1:0]       w_count, w_free;
  logic [DATA_W-1:0]   w_head;

  assign w_len       = BC_W'(min_u(32'(r_remaining), BURST_MAX));
  assign w_free      = CW'(FIFO_DEPTH) - w_count;
  assign w_push      = (r_state == S_BEATS) && flash.flash_readdatavalid;
  assign w_last_beat = w_push && (r_beats_left == BC_W'(1));

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_nxt = (word_count == '0) ? S_DONE : S_CHECK;
      S_CHECK: if (w_free >= CW'(w_len)) w_nxt = S_REQ;
      S_REQ:   if (!flash.flash_waitrequest) w_nxt = S_BEATS;
      // len never exceeds remaining, so equality means this was the final burst
      S_BEATS: if (w_last_beat) w_nxt = (r_remaining == CNT_W'(r_bc)) ? S_DRAIN : S_CHECK;
      S_DRAIN: if (w_empty) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_beats_left <= '0;
      r_faddr      <= '0;
      r_bc         <= '0;
      r_read       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_read  <= (w_nxt == S_REQ);
      r_busy  <= (w_nxt != S_IDLE);
      r_done  <= (r_state == S_DONE);
      if (r_state == S_IDLE && start) begin
        r_cur_addr  <= start_addr;
        r_remaining <= word_count;
      end
      if (r_state == S_CHECK && w_nxt == S_REQ) begin
        r_faddr <= r_cur_addr;
        r_bc    <= w_len;
      end
      if (r_state == S_REQ && w_nxt == S_BEATS) r_beats_left <= r_bc;
      else if (w_push)                          r_beats_left <= r_beats_left - BC_W'(1);
      if (w_last_beat) begin
        r_cur_addr  <= r_cur_addr + ADDR_W'(r_bc);
        r_remaining <= r_remaining - CNT_W'(r_bc);
      end
    end
  end

  // Half-select only toggles in SPLIT mode; the word pops once its high half is taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                    r_half <= 1'b0;
    else if (SPLIT != 0 && out_valid && out_ready)   r_half <= !r_half;
  end

  assign w_pop = out_valid && out_ready && ((SPLIT == 0) || r_half);

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (w_push),
    .pop    (w_pop),
    .wdata  (flash.flash_readdata),
    .rdata  (w_head),
    .empty  (w_empty),
    .full   (w_full),
    .count  (w_count)
  );

  if (SPLIT != 0) begin : g_split
    assign out_data = r_half ? w_head[DATA_W-1:DATA_W/2] : w_head[DATA_W/2-1:0];
  end else begin : g_word
    assign out_data = w_head;
  end

  assign out_valid              = !w_empty;
  assign busy                   = r_busy;
  assign done                   = r_done;
  assign flash.flash_read       = r_read;
  assign flash.flash_address    = r_faddr;
  assign flash.flash_burstcount = r_bc;
endmodule

// File: tb/tb_flash_burst_reader.sv
// Directed bench: word-mode and SPLIT-mode readers behind one flash responder model.
module tb_flash_burst_reader;
  localparam int ADDR_W = 23, DATA_W = 32, BURST_MAX = 8, CNT_W = 16, FIFO_DEPTH = 16;

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              start0 = 1'b0, start1 = 1'b0, out_ready = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              busy0, done0, ov0, busy1, done1, ov1;
  logic [31:0]       od0;
  logic [15:0]       od1;
  logic              t_wait = 1'b0, t_rvalid = 1'b0;
  logic [31:0]       t_rdata = '0;

  flash_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) f0();
  flash_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) f1();
  assign f0.flash_waitrequest   = t_wait;
  assign f0.flash_readdata      = t_rdata;
  assign f0.flash_readdatavalid = t_rvalid;
  assign f1.flash_waitrequest   = t_wait;
  assign f1.flash_readdata      = t_rdata;
  assign f1.flash_readdatavalid = t_rvalid;

  flash_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX), .CNT_W(CNT_W),
                       .FIFO_DEPTH(FIFO_DEPTH), .SPLIT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .start_addr(start_addr),
    .word_count(word_count), .busy(busy0), .done(done0), .flash(f0),
    .out_data(od0), .out_valid(ov0), .out_ready(out_ready));

  flash_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX), .CNT_W(CNT_W),
                       .FIFO_DEPTH(FIFO_DEPTH), .SPLIT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .start_addr(start_addr),
    .word_count(word_count), .busy(busy1), .done(done1), .flash(f1),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready));

  function automatic logic [31:0] mem(input logic [ADDR_W-1:0] a);
    if (a == 23'h40) return 32'hAAAA5555;
    if (a == 23'h41) return 32'h12345678;
    return 32'hC000_0000 | 32'(a);
  endfunction

  // Flash responder: wait_n stall cycles per request, then beats on consecutive cycles.
  int                pend = 0, wait_n = 0, wcnt = 0, rdhi = 0, stray = 0, stray_sent = 0;
  logic              stab_err = 1'b0, rd;
  logic [ADDR_W-1:0] raddr = '0, hold_a = '0, ad;
  logic [3:0]        hold_bc = '0, bc;
  logic [ADDR_W-1:0] b_addr[$];
  int                b_cnt[$];

  always @(negedge clk) begin
    t_rvalid = 1'b0;
    if (!reset_n) begin
      pend = 0; wcnt = 0; t_wait = 1'b0;
    end else begin
      if (pend > 0) begin
        t_rvalid = 1'b1; t_rdata = mem(raddr); raddr = raddr + 1'b1; pend--;
      end else if (stray_sent < stray) begin
        t_rvalid = 1'b1; t_rdata = 32'hDEAD0000 | 32'(stray_sent); stray_sent++;
      end
      rd = f0.flash_read | f1.flash_read;
      ad = f0.flash_read ? f0.flash_address : f1.flash_address;
      bc = f0.flash_read ? f0.flash_burstcount : f1.flash_burstcount;
      if (rd) begin
        rdhi++;
        if (wcnt == 0) begin hold_a = ad; hold_bc = bc; end
        else if (ad !== hold_a || bc !== hold_bc) stab_err = 1'b1;
        if (wcnt < wait_n) begin
          t_wait = 1'b1; wcnt++;
        end else begin
          t_wait = 1'b0; wcnt = 0; pend = int'(bc); raddr = ad;
          b_addr.push_back(ad); b_cnt.push_back(int'(bc));
        end
      end else t_wait = 1'b0;
    end
  end

  logic [31:0] q0[$];
  logic [15:0] q1[$];
  int          dn0 = 0, dn1 = 0, ovh0 = 0;
  always @(negedge clk) begin
    if (ov0 && out_ready) q0.push_back(od0);
    if (ov1 && out_ready) q1.push_back(od1);
    if (done0) dn0++;
    if (done1) dn1++;
    if (ov0) ovh0++;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_start(input bit which, input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
    start_addr = a; word_count = n;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    cyc(1);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int base, input string tag);
    int k = 0;
    while (((which ? dn1 : dn0) == base) && k < 400) begin cyc(1); k++; end
    cyc(3);
    chk({tag, "_done_once"}, 64'((which ? dn1 : dn0) - base), 64'd1);
    chk({tag, "_busy_low"}, 64'(which ? busy1 : busy0), 64'd0);
  endtask

  task automatic chk_burst(input string tag, input int idx, input logic [ADDR_W-1:0] a, input int n);
    chk({tag, "_addr"}, 64'(b_addr[idx]), 64'(a));
    chk({tag, "_cnt"}, 64'(b_cnt[idx]), 64'(n));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int bb, qb, db, hb, rb;
    cyc(3);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_read", 64'(f0.flash_read), 64'd0);
    chk("rst_addr", 64'(f0.flash_address), 64'd0);
    chk("rst_bc", 64'(f0.flash_burstcount), 64'd0);
    chk("rst_valid", 64'(ov0), 64'd0);
    reset_n = 1'b1;
    cyc(2);

    // zero-length command
    bb = b_addr.size(); hb = ovh0;
    pulse_start(0, 23'h123, 16'd0);
    chk("z_busy1", 64'(busy0), 64'd1);
    chk("z_done1", 64'(done0), 64'd0);
    cyc(1);
    chk("z_done2", 64'(done0), 64'd1);
    chk("z_busy2", 64'(busy0), 64'd0);
    cyc(1);
    chk("z_done3", 64'(done0), 64'd0);
    cyc(3);
    chk("z_no_burst", 64'(b_addr.size() - bb), 64'd0);
    chk("z_no_valid", 64'(ovh0 - hb), 64'd0);

    // 20 words in three bursts, consumer always ready
    out_ready = 1'b1;
    bb = b_addr.size(); qb = q0.size(); db = dn0;
    pulse_start(0, 23'h100, 16'd20);
    chk("b_read_early", 64'(f0.flash_read), 64'd0);
    cyc(1);
    chk("b_read", 64'(f0.flash_read), 64'd1);
    chk("b_req_addr", 64'(f0.flash_address), 64'h100);
    chk("b_req_bc", 64'(f0.flash_burstcount), 64'd8);
    wait_done(0, db, "b");
    chk("b_nbursts", 64'(b_addr.size() - bb), 64'd3);
    chk_burst("b0", bb, 23'h100, 8);
    chk_burst("b1", bb + 1, 23'h108, 8);
    chk_burst("b2", bb + 2, 23'h110, 4);
    chk("b_nwords", 64'(q0.size() - qb), 64'd20);
    for (int i = 0; i < 20; i++) chk($sformatf("b_word%0d", i), 64'(q0[qb + i]), 64'(mem(ADDR_W'(23'h100 + i))));

    // 5-cycle waitrequest stall per request, address wraps between bursts
    wait_n = 5; rb = rdhi; bb = b_addr.size(); qb = q0.size(); db = dn0;
    pulse_start(0, 23'h7FFFFC, 16'd10);
    cyc(4);
    chk("w_read_held", 64'(f0.flash_read), 64'd1);
    chk("w_addr_held", 64'(f0.flash_address), 64'h7FFFFC);
    chk("w_bc_held", 64'(f0.flash_burstcount), 64'd8);
    wait_done(0, db, "w");
    wait_n = 0;
    chk("w_stable", 64'(stab_err), 64'd0);
    chk("w_read_cycles", 64'(rdhi - rb), 64'd12);
    chk("w_nbursts", 64'(b_addr.size() - bb), 64'd2);
    chk_burst("w0", bb, 23'h7FFFFC, 8);
    chk_burst("w1", bb + 1, 23'h000004, 2);
    chk("w_nwords", 64'(q0.size() - qb), 64'd10);
    for (int i = 0; i < 10; i++) chk($sformatf("w_word%0d", i), 64'(q0[qb + i]), 64'(mem(ADDR_W'(23'h7FFFFC + i))));

    // back-pressure: FIFO fills after two bursts, third waits for 8 free entries
    out_ready = 1'b0; bb = b_addr.size(); qb = q0.size(); db = dn0;
    pulse_start(0, 23'h200, 16'd32);
    cyc(60);
    chk("p_two_bursts", 64'(b_addr.size() - bb), 64'd2);
    chk("p_valid", 64'(ov0), 64'd1);
    chk("p_head_stable", 64'(od0), 64'(mem(23'h200)));
    chk("p_busy", 64'(busy0), 64'd1);
    out_ready = 1'b1; cyc(7); out_ready = 1'b0;
    cyc(6);
    chk("p_seven_popped", 64'(q0.size() - qb), 64'd7);
    chk("p_still_two", 64'(b_addr.size() - bb), 64'd2);
    chk("p_head7", 64'(od0), 64'(mem(23'h207)));
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    cyc(6);
    chk("p_third_burst", 64'(b_addr.size() - bb), 64'd3);
    out_ready = 1'b1;
    wait_done(0, db, "p");
    chk("p_nbursts", 64'(b_addr.size() - bb), 64'd4);
    chk_burst("p2", bb + 2, 23'h210, 8);
    chk_burst("p3", bb + 3, 23'h218, 8);
    chk("p_nwords", 64'(q0.size() - qb), 64'd32);
    for (int i = 0; i < 32; i++) chk($sformatf("p_word%0d", i), 64'(q0[qb + i]), 64'(mem(ADDR_W'(23'h200 + i))));

    // halfword output, low half first
    qb = q1.size(); db = dn1;
    pulse_start(1, 23'h40, 16'd2);
    wait_done(1, db, "s");
    chk("s_nhalves", 64'(q1.size() - qb), 64'd4);
    chk("s_h0", 64'(q1[qb]), 64'h5555);
    chk("s_h1", 64'(q1[qb + 1]), 64'hAAAA);
    chk("s_h2", 64'(q1[qb + 2]), 64'h5678);
    chk("s_h3", 64'(q1[qb + 3]), 64'h1234);
    chk("s_valid_low", 64'(ov1), 64'd0);

    // reset in the middle of a burst, then stray beats after release
    out_ready = 1'b0; db = dn0;
    pulse_start(0, 23'h300, 16'd8);
    cyc(4);
    chk("r_busy_before", 64'(busy0), 64'd1);
    reset_n = 1'b0;
    cyc(1);
    chk("r_busy", 64'(busy0), 64'd0);
    chk("r_valid", 64'(ov0), 64'd0);
    chk("r_read", 64'(f0.flash_read), 64'd0);
    chk("r_addr", 64'(f0.flash_address), 64'd0);
    chk("r_bc", 64'(f0.flash_burstcount), 64'd0);
    chk("r_done", 64'(done0), 64'd0);
    reset_n = 1'b1; stray = 3;
    cyc(6);
    chk("r_stray_empty", 64'(ov0), 64'd0);
    chk("r_stray_idle", 64'(busy0), 64'd0);
    chk("r_no_done", 64'(dn0 - db), 64'd0);
    out_ready = 1'b1; bb = b_addr.size(); qb = q0.size();
    pulse_start(0, 23'h400, 16'd4);
    wait_done(0, db, "r");
    chk("r_nbursts", 64'(b_addr.size() - bb), 64'd1);
    chk_burst("r0", bb, 23'h400, 4);
    chk("r_nwords", 64'(q0.size() - qb), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("r_word%0d", i), 64'(q0[qb + i]), 64'(mem(ADDR_W'(23'h400 + i))));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
